// File: rtl/dsp_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module      : dsp_addsub_seq
// Description : Multi-cycle add/sub/accumulate engine. It adds one SLICE-bit
//               slice per cycle and registers the carry between slices.
// Revision    : 1.0 - initial release
// ============================================================================
module dsp_addsub_seq #(
  parameter int WIDTH = 64,
  parameter int SLICE = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry_out,
  output logic             overflow
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NSLICE - 1);

  localparam logic [1:0] OP_ADD  = 2'b00;
  localparam logic [1:0] OP_SUB  = 2'b01;
  localparam logic [1:0] OP_ACC  = 2'b10;
  localparam logic [1:0] OP_LOAD = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state, state_nxt;
  logic [WIDTH-1:0]  op_a, op_b, acc;
  logic [WIDTH-1:0]  op_b_sel;
  logic [WIDTH-1:0]  result_shift;
  logic [SLICE:0]    slice_sum;
  logic [IDXW-1:0]   idx;
  logic [1:0]        op_q;
  logic              carry, carry_sel;
  logic              sign_a, sign_b;
  logic              accept, last_slice;

  assign in_ready   = (state == IDLE);
  assign out_valid  = (state == DONE);
  assign accept     = in_valid && in_ready;
  assign last_slice = (idx == IDX_LAST);

  assign slice_sum = {1'b0, op_a[SLICE-1:0]} + {1'b0, op_b[SLICE-1:0]}
                   + {{SLICE{1'b0}}, carry};

  // New slice enters at the top so the LSB slice ends up at the bottom.
  generate
    if (NSLICE == 1) begin : g_shift_single
      assign result_shift = slice_sum[SLICE-1:0];
    end else begin : g_shift_multi
      assign result_shift = {slice_sum[SLICE-1:0], result[WIDTH-1:SLICE]};
    end
  endgenerate

  always_comb begin
    op_b_sel  = b;
    carry_sel = 1'b0;
    case (op)
      OP_ADD:  begin op_b_sel = b;  carry_sel = 1'b0; end
      OP_SUB:  begin op_b_sel = ~b; carry_sel = 1'b1; end
      OP_ACC:  begin op_b_sel = acc; carry_sel = 1'b0; end
      OP_LOAD: begin op_b_sel = '0; carry_sel = 1'b0; end
      default: begin op_b_sel = b;  carry_sel = 1'b0; end
    endcase
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (in_valid)   state_nxt = RUN;
      RUN:     if (last_slice) state_nxt = DONE;
      DONE:    if (out_ready)  state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_a      <= '0;
      op_b      <= '0;
      acc       <= '0;
      result    <= '0;
      idx       <= '0;
      op_q      <= OP_ADD;
      carry     <= 1'b0;
      sign_a    <= 1'b0;
      sign_b    <= 1'b0;
      carry_out <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      if (accept) begin
        op_a   <= a;
        op_b   <= op_b_sel;
        carry  <= carry_sel;
        sign_a <= a[WIDTH-1];
        sign_b <= op_b_sel[WIDTH-1];
        op_q   <= op;
        idx    <= '0;
      end else if (state == RUN) begin
        result <= result_shift;
        op_a   <= op_a >> SLICE;
        op_b   <= op_b >> SLICE;
        carry  <= slice_sum[SLICE];
        idx    <= idx + 1'b1;
        if (last_slice) begin
          carry_out <= slice_sum[SLICE];
          overflow  <= (op_q != OP_LOAD) && (sign_a == sign_b)
                       && (slice_sum[SLICE-1] != sign_a);
          if (op_q[1]) begin
            acc <= result_shift;
          end
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_dsp_addsub_seq.sv
`default_nettype none
// ============================================================================
// Module      : tb_dsp_addsub_seq
// Description : Randomised and directed bench for dsp_addsub_seq.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dsp_addsub_seq;

  localparam int WIDTH  = 64;
  localparam int SLICE  = 16;
  localparam int NSLICE = WIDTH / SLICE;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             in_ready;
  logic [1:0]       op = 2'b00;
  logic [WIDTH-1:0] a = '0;
  logic [WIDTH-1:0] b = '0;
  logic             out_valid;
  logic             out_ready = 1'b0;
  logic [WIDTH-1:0] result;
  logic             carry_out;
  logic             overflow;

  int n_checks = 0;
  int n_pass   = 0;
  logic [WIDTH-1:0] acc_m = '0;

  always #5 clk = ~clk;

  dsp_addsub_seq #(.WIDTH(WIDTH), .SLICE(SLICE)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .op(op), .a(a), .b(b), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .carry_out(carry_out), .overflow(overflow)
  );

  task automatic check_eq(input string tag, input logic [WIDTH-1:0] obs,
                          input logic [WIDTH-1:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
  endtask

  // Reference: plain wide arithmetic on the operands, signed-overflow rules.
  task automatic model(input logic [1:0] o, input logic [WIDTH-1:0] x, y,
                       output logic [WIDTH-1:0] r, output logic c, ov);
    logic [WIDTH:0] s;
    case (o)
      2'b00, 2'b10: begin
        if (o == 2'b10) y = acc_m;
        s  = {1'b0, x} + {1'b0, y};
        r  = s[WIDTH-1:0];
        c  = s[WIDTH];
        ov = (x[WIDTH-1] == y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
        if (o == 2'b10) acc_m = r;
      end
      2'b01: begin
        r  = x - y;
        c  = (x >= y);
        ov = (x[WIDTH-1] != y[WIDTH-1]) && (r[WIDTH-1] != x[WIDTH-1]);
      end
      default: begin
        r = x; c = 1'b0; ov = 1'b0; acc_m = x;
      end
    endcase
  endtask

  task automatic run_op(input logic [1:0] o, input logic [WIDTH-1:0] x, y,
                        input int hold, output logic [WIDTH-1:0] r_obs,
                        output logic c_obs, ov_obs);
    logic [WIDTH-1:0] r_exp;
    logic c_exp, ov_exp;
    int t = 0;
    int lat = 0;
    @(negedge clk);
    while (!in_ready && t < 50) begin @(negedge clk); t++; end
    check_eq("in_ready_before_req", {63'd0, in_ready}, 64'd1);
    op = o; a = x; b = y; in_valid = 1'b1;
    model(o, x, y, r_exp, c_exp, ov_exp);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    op = 2'($urandom); a = {$urandom, $urandom}; b = {$urandom, $urandom};
    while (lat < 20) begin
      @(posedge clk); lat++;
      #1;
      if (out_valid) break;
    end
    check_eq("latency", 64'(lat), 64'(NSLICE));
    r_obs = result; c_obs = carry_out; ov_obs = overflow;
    check_eq("result", result, r_exp);
    check_eq("carry_out", {63'd0, carry_out}, {63'd0, c_exp});
    check_eq("overflow", {63'd0, overflow}, {63'd0, ov_exp});
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      in_valid = 1'($urandom); op = 2'($urandom);
      a = {$urandom, $urandom}; b = {$urandom, $urandom};
      @(posedge clk); #1;
      check_eq("hold_result", result, r_exp);
      check_eq("hold_flags", {62'd0, carry_out, overflow}, {62'd0, c_exp, ov_exp});
      check_eq("hold_ready_valid", {62'd0, in_ready, out_valid}, 64'd1);
    end
    @(negedge clk);
    in_valid = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check_eq("post_handshake", {62'd0, in_ready, out_valid}, 64'd2);
  endtask

  initial begin
    logic [WIDTH-1:0] r;
    logic c, ov;
    logic [WIDTH-1:0] edges [4];
    edges[0] = '0; edges[1] = '1;
    edges[2] = 64'h8000_0000_0000_0000; edges[3] = 64'h7FFF_FFFF_FFFF_FFFF;

    #12;
    check_eq("reset_outputs", {61'd0, out_valid, carry_out, overflow}, 64'd0);
    check_eq("reset_result", result, '0);
    @(negedge clk); rst_n = 1'b1;
    #1;
    check_eq("reset_in_ready", {63'd0, in_ready}, 64'd1);

    run_op(2'b00, '1, 64'd1, 0, r, c, ov);
    check_eq("add_wrap", {r[61:0], c, ov}, {62'd0, 1'b1, 1'b0});
    run_op(2'b00, 64'h0000_0000_0000_FFFF, 64'd1, 0, r, c, ov);
    check_eq("add_slice_carry", r, 64'h0000_0000_0001_0000);
    check_eq("add_slice_cout", {63'd0, c}, 64'd0);
    run_op(2'b01, 64'd0, 64'd1, 0, r, c, ov);
    check_eq("sub_borrow", r, '1);
    check_eq("sub_borrow_flags", {62'd0, c, ov}, 64'd0);
    run_op(2'b01, 64'h8000_0000_0000_0000, 64'd1, 0, r, c, ov);
    check_eq("sub_ovf", r, 64'h7FFF_FFFF_FFFF_FFFF);
    check_eq("sub_ovf_flag", {63'd0, ov}, 64'd1);

    run_op(2'b11, 64'd5, {$urandom, $urandom}, 0, r, c, ov);
    check_eq("load5", r, 64'd5);
    run_op(2'b10, 64'd3, {$urandom, $urandom}, 0, r, c, ov);
    check_eq("acc8", r, 64'd8);
    run_op(2'b10, '1, {$urandom, $urandom}, 10, r, c, ov);
    check_eq("acc_wrap", r, 64'd7);
    check_eq("acc_wrap_flags", {62'd0, c, ov}, 64'd2);

    for (int i = 0; i < 30; i++) begin
      logic [WIDTH-1:0] x, y;
      x = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : {$urandom, $urandom};
      y = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : {$urandom, $urandom};
      run_op(2'($urandom), x, y, $urandom_range(0, 3), r, c, ov);
    end

    // Abort an ACC mid-RUN with reset.
    @(negedge clk);
    op = 2'b10; a = 64'd9; in_valid = 1'b1;
    @(posedge clk); #1; in_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check_eq("abort_out_valid", {63'd0, out_valid}, 64'd0);
    check_eq("abort_result", result, '0);
    @(negedge clk); rst_n = 1'b1;
    acc_m = '0;
    run_op(2'b10, 64'd2, '0, 0, r, c, ov);
    check_eq("acc_after_abort", r, 64'd2);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
